// File: rtl/dds_pkg.sv
// Shared constants for the DDS frequency-sweep sequencer: FSM state encoding,
// sweep mode codes and default widths.
package dds_pkg;

  localparam int DEF_M_W     = 6;
  localparam int DEF_DWELL_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DWELL = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/sweep_step_alu.sv
// Combinational add/subtract of one frequency step, clamped so the result never
// passes the endpoint it is heading toward.
module sweep_step_alu #(
  parameter int M_W = 6
) (
  input  logic [M_W-1:0] cur,
  input  logic [M_W-1:0] step,
  input  logic [M_W-1:0] endpoint,
  input  logic           dir,
  output logic [M_W-1:0] next,
  output logic           at_end
);

  logic [M_W:0] sum;
  logic [M_W:0] diff;

  always_comb begin
    sum    = {1'b0, cur} + {1'b0, step};
    diff   = {1'b0, cur} - {1'b0, step};
    at_end = (cur == endpoint);
    next   = endpoint;
    if (dir) begin
      if (sum < {1'b0, endpoint}) next = sum[M_W-1:0];
    end else begin
      // diff[M_W] set means the subtraction wrapped below zero
      if (!diff[M_W] && (diff[M_W-1:0] > endpoint)) next = diff[M_W-1:0];
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS M word: single, repeat, triangle
// and hold sweeps with a tick-enabled dwell counter per word.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int M_W     = DEF_M_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [M_W-1:0]     m_start,
  input  logic [M_W-1:0]     m_stop,
  input  logic [M_W-1:0]     m_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [M_W-1:0]     freq_word,
  output logic               phase_rst,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  logic [2:0]         state;
  logic [1:0]         mode_r;
  logic [M_W-1:0]     start_r;
  logic [M_W-1:0]     stop_r;
  logic [M_W-1:0]     step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] cnt;

  logic [M_W-1:0] hi;
  logic [M_W-1:0] lo;
  logic [M_W-1:0] tgt;
  logic [M_W-1:0] rev_tgt;
  logic [M_W-1:0] fwd_next;
  logic [M_W-1:0] rev_next;
  logic           at_end;
  logic           rev_at_end;

  always_comb begin
    hi      = (start_r >= stop_r) ? start_r : stop_r;
    lo      = (start_r >= stop_r) ? stop_r : start_r;
    tgt     = dir ? hi : lo;
    rev_tgt = dir ? lo : hi;
  end

  sweep_step_alu #(.M_W(M_W)) u_fwd (
    .cur(freq_word), .step(step_r), .endpoint(tgt), .dir(dir),
    .next(fwd_next), .at_end(at_end)
  );

  // Triangle turnaround: one step already taken in the reversed direction.
  sweep_step_alu #(.M_W(M_W)) u_rev (
    .cur(freq_word), .step(step_r), .endpoint(rev_tgt), .dir(~dir),
    .next(rev_next), .at_end(rev_at_end)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= MODE_SINGLE;
      start_r   <= '0;
      stop_r    <= '0;
      step_r    <= M_W'(1);
      dwell_r   <= DWELL_W'(1);
      cnt       <= '0;
      freq_word <= '0;
      phase_rst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir       <= 1'b1;
    end else begin
      phase_rst <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              mode_r  <= mode;
              start_r <= m_start;
              stop_r  <= m_stop;
              step_r  <= (m_step == '0) ? M_W'(1) : m_step;
              dwell_r <= (dwell == '0) ? DWELL_W'(1) : dwell;
              state   <= S_LOAD;
            end
          end
          S_LOAD: begin
            freq_word <= start_r;
            phase_rst <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            dir       <= (start_r <= stop_r);
            state     <= S_DWELL;
          end
          S_DWELL: begin
            if (tick_en && (mode_r != MODE_HOLD)) begin
              if (cnt == dwell_r - DWELL_W'(1)) begin
                cnt   <= '0;
                state <= S_STEP;
              end else begin
                cnt <= cnt + DWELL_W'(1);
              end
            end
          end
          S_STEP: begin
            state <= S_DWELL;
            if (!at_end) begin
              freq_word <= fwd_next;
            end else begin
              case (mode_r)
                MODE_SINGLE: begin
                  state <= S_DONE;
                  done  <= 1'b1;
                end
                MODE_REPEAT: begin
                  freq_word <= start_r;
                  phase_rst <= 1'b1;
                end
                MODE_TRI: begin
                  dir <= ~dir;
                  // Equal endpoints: nowhere to go, keep the word.
                  if (!rev_at_end) freq_word <= rev_next;
                end
                default: ;
              endcase
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the `DDS` waveform generator. It steps the DDS frequency control word M from a start value to a stop value, holding each value for a programmable number of sample ticks. It supports single, repeating and triangle sweeps, plus a fixed-tone hold. It sits between the control logic and the `DDS` M input, and runs in the `sys_clk` domain with the `freq_div10` output as its tick enable.

## Interface
- `M_W`, 6: width of the frequency control word (matches `DDS` M input).
- `DWELL_W`, 16: width of the dwell counter (ticks per frequency step).
- `sys_clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tick_en` input 1: sample-tick enable, one `sys_clk`-cycle pulse per DDS sample; the dwell counter advances only on it.
- `start` input 1: one-cycle request to begin a sweep; honoured only in IDLE.
- `abort` input 1: stops any sweep; takes priority over every other input.
- `mode` input 2: 00 single pass, 01 repeat, 10 triangle, 11 hold.
- `m_start` input M_W: first frequency word.
- `m_stop` input M_W: last frequency word.
- `m_step` input M_W: increment magnitude; 0 is treated as 1.
- `dwell` input DWELL_W: ticks per word; 0 is treated as 1.
- `freq_word` output M_W: drives `DDS` M; reset value 0.
- `phase_rst` output 1: one-cycle pulse that clears the DDS phase accumulator; reset value 0.
- `busy` output 1: high from LOAD until return to IDLE; reset value 0.
- `done` output 1: one-cycle pulse at the end of a completed single pass; reset value 0.
- `dir` output 1: current direction, 1 = up; reset value 1.

## Operation
- The FSM states are IDLE, LOAD, DWELL, STEP and DONE.
- **IDLE:**
  - `start`=1 → LOAD. `mode`, `m_start`, `m_stop`, `m_step` and `dwell` are captured into registers on this edge.
  - Later input changes have no effect until the next start.
- **LOAD** (1 cycle):
  - `freq_word`←`m_start`, `phase_rst`=1, `busy`=1, dwell counter cleared.
  - `dir`←1 if `m_start`≤`m_stop`, else 0.
  - Next state: DWELL.
- **DWELL:**
  - The counter increments on each `tick_en`.
  - When the count reaches the effective dwell → STEP. In hold mode, DWELL never exits.
- **STEP** (1 cycle): compute next = `freq_word` ± step in M_W+1 bits.
  - Not at the endpoint: if next passes or equals the target endpoint, `freq_word`←endpoint; otherwise `freq_word`←next. Then → DWELL.
  - Already at the endpoint (its dwell has completed):
    - Single: → DONE.
    - Repeat: `freq_word`←`m_start`, `phase_rst`=1, → DWELL.
    - Triangle: `dir` toggles, the target becomes the other endpoint, one step is applied in the new direction (clamped), → DWELL.
- **DONE** (1 cycle): `done`=1, → IDLE; `busy` falls on the same edge as the IDLE entry.
- `m_start`==`m_stop`: a single pass gives one dwell, then DONE. Repeat and triangle hold the word indefinitely.
- `abort` in any non-IDLE state → IDLE on the next edge with no `done`. `freq_word` keeps its last value.
- `start` while busy is ignored. `start` and `abort` in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- `rst` mid-sweep: all outputs return to their reset values on the next edge.

## Timing
- start→`busy`/`phase_rst`/new `freq_word`: registered output 2 edges after `start` is sampled (IDLE→LOAD, then LOAD outputs).
- Each word is held for exactly max(`dwell`,1) `tick_en` pulses, plus 1 `sys_clk` for STEP.
- A `tick_en` arriving during the LOAD or STEP cycle is not counted.
- `done` asserts 1 `sys_clk` after the final STEP.
- With `tick_en` tied high, each word occupies `dwell`+1 `sys_clk` cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- The shared package `dds_pkg` holds:
  - the state encoding localparams (IDLE=0 … DONE=4);
  - the mode codes `MODE_SINGLE`, `MODE_REPEAT`, `MODE_TRI`, `MODE_HOLD`;
  - the default `M_W`.
- One sub-module, `sweep_step_alu`: combinational clamp-to-endpoint add/subtract (inputs: current word, step, endpoint, dir; outputs: next word, at_end). The FSM and counters stay in `dds_sweep_ctrl`.

## Test plan
- Single up: `tick_en`=1, mode 00, start 1, stop 10, step 3, dwell 4 → `freq_word` sequence 1, 4, 7, 10, each held 5 cycles; then one `done` pulse and `busy`=0.
- Single down with clamp: start 20, stop 5, step 6 → 20, 14, 8, 5 with `dir`=0. A `m_step`=0 variant with start 3, stop 5 steps 3, 4, 5.
- Triangle: start 2, stop 6, step 2, dwell 1 → 2, 4, 6, 4, 2, 4, … with `dir` toggling at 6 and 2, `done` never asserting; `abort` gives IDLE next edge, `freq_word` frozen.
- Repeat with `phase_rst`: start 0, stop 4, step 2 → 0, 2, 4, 0, …; `phase_rst` pulses at LOAD and at each wrap to 0.
- Sparse ticks: `tick_en` every 10 cycles, dwell 2 → each word is held 20 cycles + 1; a tick coincident with STEP is not counted.
- Reset and priority cases: `rst` mid-DWELL → all outputs return to reset values; start+abort in the same cycle → `busy` stays 0; start during busy → ignored.
